operand_handler_seq: RTL and testbench

- Sequential, parametrised successor to the execute-stage operand handler.
- Produces the ALU second operand N from register RB and instruction immediate I under a 3-bit select.
- Shifts are done by an iterative shifter, STEP bits per cycle, to trade area for latency; the shift amount comes from the instruction field or a register.
- Valid/ready handshakes on both sides let the control unit stall around multi-cycle shifts.

---
 rtl/operand_handler_seq.sv | 149 ++++++++++++++
 tb/tb_operand_handler_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_handler_seq.sv
// Sequential ALU second-operand generator.
// Immediate and pass-through selects resolve in one cycle. Shift selects go
// through an iterative shifter that moves STEP bits per cycle. Valid/ready
// handshakes on both sides let the control unit stall around long shifts.
module operand_handler_seq #(
    parameter int unsigned STEP   = 4,    // bits shifted per SHIFT cycle, 1..31
    parameter bit          ROT_EN = 1'b1  // 1: sel 111 rotates right, 0: sel 111 yields zero
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rb,
    input  logic [20:0] imm,
    input  logic [2:0]  sel,
    input  logic        sa_src,
    input  logic [4:0]  sa_reg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] n,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [2:0] SelRb   = 3'b000;
    localparam logic [2:0] SelImmA = 3'b001;
    localparam logic [2:0] SelImmB = 3'b010;
    localparam logic [2:0] SelImmU = 3'b011;
    localparam logic [2:0] SelSrl  = 3'b100;
    localparam logic [2:0] SelSra  = 3'b101;
    localparam logic [2:0] SelSll  = 3'b110;
    localparam logic [2:0] SelRor  = 3'b111;

    localparam logic [4:0] StepAmt = 5'(STEP);

    state_e      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [2:0]  sel_q, sel_d;
    logic [4:0]  rem_q, rem_d;

    logic        accept;
    logic [4:0]  amt_in;
    logic        shift_in;
    logic [31:0] direct_val;
    logic [4:0]  step_k;
    logic [31:0] step_val;

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = !reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
        accept    = in_valid && in_ready;
        out_valid = (state_q == StDone);
        busy      = (state_q == StShift);
        n         = n_q;
    end

    // Decode the incoming request: amount source, shift class and the
    // single-cycle result for non-shift selects.
    always_comb begin
        // imm[9:5] <= 31, so the subtraction never leaves the 5-bit range
        amt_in   = sa_src ? sa_reg : (5'd31 - imm[9:5]);
        shift_in = sel[2] && ((sel != SelRor) || ROT_EN);
        direct_val = 32'h0;
        case (sel)
            SelRb:   direct_val = rb;
            SelImmA: direct_val = {{22{imm[0]}}, imm[10:1]};
            SelImmB: direct_val = {{19{imm[0]}}, imm[13:1]};
            SelImmU: direct_val = {imm, 11'b0};
            default: direct_val = 32'h0;  // shift selects never use this path
        endcase
    end

    // One shifter step: move by min(STEP, rem) in the direction of the latched select.
    always_comb begin
        step_k   = (rem_q < StepAmt) ? rem_q : StepAmt;
        step_val = n_q;
        case (sel_q)
            SelSrl:  step_val = n_q >> step_k;
            SelSra:  step_val = 32'($signed(n_q) >>> step_k);
            SelSll:  step_val = n_q << step_k;
            SelRor:  step_val = (n_q >> step_k) | (n_q << (6'd32 - {1'b0, step_k}));
            default: step_val = n_q;
        endcase
    end

    // Next-state logic; an accepted request overrides whatever the state chose.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        sel_d   = sel_q;
        rem_d   = rem_q;

        case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StShift: begin
                n_d   = step_val;
                rem_d = rem_q - step_k;
                if (rem_q == step_k) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Accept from IDLE, or from DONE in the same cycle the result is taken.
        if (accept) begin
            sel_d = sel;
            if (shift_in) begin
                n_d     = rb;
                rem_d   = amt_in;
                state_d = (amt_in == 5'd0) ? StDone : StShift;
            end else begin
                n_d     = direct_val;
                rem_d   = 5'd0;
                state_d = StDone;
            end
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= 32'h0;
            sel_q   <= 3'b000;
            rem_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_operand_handler_seq.sv
// Self-checking bench for operand_handler_seq: directed test-plan cases plus
// randomized requests against a whole-operation arithmetic reference model.
module tb_operand_handler_seq;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rb = 32'h0;
    logic [20:0] imm = 21'h0;
    logic [2:0]  sel = 3'b000;
    logic        sa_src = 1'b0;
    logic [4:0]  sa_reg = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] n;
    logic        busy;

    // Second instance for the legacy (no rotate) encoding.
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] n2;
    logic        busy2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_handler_seq #(
        .STEP   (STEP),
        .ROT_EN (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rb        (rb),
        .imm       (imm),
        .sel       (sel),
        .sa_src    (sa_src),
        .sa_reg    (sa_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .busy      (busy)
    );

    operand_handler_seq #(
        .STEP   (STEP),
        .ROT_EN (1'b0)
    ) dut_nr (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .rb        (rb),
        .imm       (imm),
        .sel       (sel),
        .sa_src    (sa_src),
        .sa_reg    (sa_reg),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .n         (n2),
        .busy      (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ref_amt(input logic [20:0] i, input logic src, input logic [4:0] sreg);
        if (src) return int'(sreg);
        return 31 - int'(i[9:5]);
    endfunction

    function automatic bit ref_is_shift(input logic [2:0] s, input bit rot);
        return (int'(s) >= 4) && !((s == 3'b111) && !rot);
    endfunction

    // Result of the whole operation in one go, no stepping.
    function automatic logic [31:0] ref_n(input logic [31:0] a, input logic [20:0] i,
                                          input logic [2:0] s, input int amt, input bit rot);
        logic [63:0] dbl;
        case (s)
            3'd0: return a;
            3'd1: return {{22{i[0]}}, i[10:1]};
            3'd2: return {{19{i[0]}}, i[13:1]};
            3'd3: return {i, 11'b0};
            3'd4: return a >> amt;
            3'd5: return 32'($signed(a) >>> amt);
            3'd6: return a << amt;
            default: begin
                dbl = {a, a};
                return rot ? dbl[amt +: 32] : 32'h0;
            end
        endcase
    endfunction

    // Issue one request to the rotate-enabled instance and check result,
    // latency and busy duration. Inputs are scrambled right after accept.
    task automatic run_op(input string tag, input logic [31:0] a_rb, input logic [20:0] a_imm,
                          input logic [2:0] a_sel, input logic a_src, input logic [4:0] a_sreg);
        int          amt;
        int          exp_busy;
        int          lat;
        int          bcnt;
        logic [31:0] exp_n;
        amt      = ref_amt(a_imm, a_src, a_sreg);
        exp_n    = ref_n(a_rb, a_imm, a_sel, amt, 1'b1);
        exp_busy = (ref_is_shift(a_sel, 1'b1) && amt != 0) ? (amt + STEP - 1) / STEP : 0;

        @(negedge clk);
        rb        = a_rb;
        imm       = a_imm;
        sel       = a_sel;
        sa_src    = a_src;
        sa_reg    = a_sreg;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rb       = $urandom;
        imm      = 21'($urandom);
        sel      = 3'($urandom);
        sa_src   = 1'($urandom);
        sa_reg   = 5'($urandom);
        lat  = 1;
        bcnt = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(1 + exp_busy));
        chk({tag, " n"}, n, exp_n);
        chk({tag, " busy cycles"}, 32'(bcnt), 32'(exp_busy));
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] exp_b;
        bit          spurious;

        // Reset state
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset n", n, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Immediate modes
        run_op("imm sel001", 32'h1234_5678, 21'h104761, 3'b001, 1'b0, 5'd0);
        run_op("imm sel011", 32'h1234_5678, 21'h104761, 3'b011, 1'b0, 5'd0);
        run_op("imm sel010", 32'hCAFE_F00D, 21'h104761, 3'b010, 1'b0, 5'd0);
        run_op("pass sel000", 32'hCAFE_F00D, 21'h0, 3'b000, 1'b1, 5'd17);

        // Field-amount shifts (amt = 4)
        run_op("field srl", 32'h8431_FFEB, 21'h104761, 3'b100, 1'b0, 5'd0);
        run_op("field sra", 32'h8431_FFEB, 21'h104761, 3'b101, 1'b0, 5'd0);
        run_op("field sll", 32'h8431_FFEB, 21'h104761, 3'b110, 1'b0, 5'd0);
        run_op("field ror", 32'h8431_FFEB, 21'h104761, 3'b111, 1'b0, 5'd0);

        // Register amount, multi-step, and zero amount
        run_op("reg sra9", 32'h8000_0000, 21'h0, 3'b101, 1'b1, 5'd9);
        run_op("reg srl9", 32'h8000_0000, 21'h0, 3'b100, 1'b1, 5'd9);
        run_op("reg amt0", 32'h8000_0000, 21'h0, 3'b101, 1'b1, 5'd0);
        run_op("reg ror31", 32'h0000_0001, 21'h0, 3'b111, 1'b1, 5'd31);
        run_op("field amt0", 32'hA5A5_0F0F, 21'h0003E0, 3'b110, 1'b0, 5'd0);

        // Backpressure: hold the result for 5 cycles, then take it while issuing
        @(negedge clk);
        rb        = 32'hDEAD_BEEF;
        sel       = 3'b000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rb       = 32'h0;
        held     = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall n", n, held);
            chk("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        imm       = 21'h1ABCDE;
        sel       = 3'b011;
        exp_b     = ref_n(32'h0, 21'h1ABCDE, 3'b011, 0, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b out_valid", 32'(out_valid), 32'd1);
        chk("b2b n", n, exp_b);

        // Reset during SHIFT discards the operation
        @(negedge clk);
        rb       = 32'hFFFF_FFFF;
        sel      = 3'b100;
        sa_src   = 1'b1;
        sa_reg   = 5'd31;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset n", n, 32'h0);
        chk("midreset busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        spurious = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
        end
        chk("midreset no output", 32'(spurious), 32'd0);

        // Legacy encoding: sel 111 is a one-cycle zero, never busy
        @(negedge clk);
        rb         = 32'h8431_FFEB;
        sel        = 3'b111;
        sa_src     = 1'b1;
        sa_reg     = 5'd9;
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        #1;
        chk("norot in_ready", 32'(in_ready2), 32'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("norot out_valid", 32'(out_valid2), 32'd1);
        chk("norot n", n2, 32'h0);
        chk("norot busy", 32'(busy2), 32'd0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom, 21'($urandom), 3'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
